// File: rtl/alu24_pkg.sv
// Shared definitions for the bit-serial 24-bit ALU.
// Holds the datapath width, the Ctrl encodings ({BNegate, Op[1:0]}) and the
// sequencer state enum. Imported by alu_bit_slice and alu24_serial.
package alu24_pkg;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_SLT = 3'b111;
    localparam logic [2:0] CTRL_XOR = 3'b011;

    // Slice-level op codes
    localparam logic [1:0] SOP_AND = 2'b00;
    localparam logic [1:0] SOP_OR  = 2'b01;
    localparam logic [1:0] SOP_ADD = 2'b10;
    localparam logic [1:0] SOP_X   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice driven by the serial sequencer.
// Ports:
//   a, b      operand bits
//   binvert   invert b before use (subtract)
//   cin       carry in
//   less      pass-through bit for set-less-than style chains
//   op        00 AND, 01 OR, 10 ADD, 11 XOR/LESS (see below)
//   result    selected result bit
//   carry_out full-adder carry out (always computed)
// Macro ALU24_SERIAL_XOR_EN: op 11 with binvert=0 gives a ^ b; otherwise
// op 11 passes 'less' through.
module alu_bit_slice
    import alu24_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       binvert,
    input  logic       cin,
    input  logic       less,
    input  logic [1:0] op,
    output logic       result,
    output logic       carry_out
);

    logic bb;
    logic sum;

    always_comb begin
        bb        = b ^ binvert;
        sum       = a ^ bb ^ cin;
        carry_out = (a & bb) | (a & cin) | (bb & cin);
    end

    always_comb begin
        result = 1'b0;
        case (op)
            SOP_AND: result = a & bb;
            SOP_OR:  result = a | bb;
            SOP_ADD: result = sum;
`ifdef ALU24_SERIAL_XOR_EN
            SOP_X:   result = binvert ? less : (a ^ bb);
`else
            SOP_X:   result = less;
`endif
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu24_serial.sv
// Bit-serial 24-bit ALU sequencer. Captures a full-width operation, feeds one
// alu_bit_slice LSB-first for WIDTH cycles with registered carry feedback,
// then publishes the assembled result and flags with a one-cycle done pulse.
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   start       request, accepted in IDLE or on the done cycle
//   a, b, ctrl  operands and {BNegate, Op[1:0]}, captured on acceptance
//   result      final result, held until the next done
//   carry_out   MSB carry (ADD/SUB only)
//   overflow    signed overflow (ADD/SUB/SLT only)
//   zero        result == 0
//   busy        high during the WIDTH shift cycles
//   done        one-cycle pulse, outputs valid from this cycle
// Macro ALU24_SERIAL_XOR_EN enables Ctrl 011 (XOR); otherwise it yields 0.
module alu24_serial
    import alu24_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_sh_q, b_sh_q;
    // Only WIDTH-1 bits are stored: the MSB comes live from the slice.
    logic [WIDTH-2:0] r_sh_q;
    logic [2:0]       ctrl_q;
    logic             carry_q;
    logic [CNT_W-1:0] bitcnt_q;

    logic [WIDTH-1:0] result_q;
    logic             cout_q, ovf_q, zero_q;

    logic       accept, last_bit;
    logic [1:0] slice_op;
    logic       slice_res, slice_cout;

    logic [WIDTH-1:0] res_full, res_fin;
    logic             msb_ovf, less_bit, cout_fin, ovf_fin;

    assign accept   = start && (state_q == ST_IDLE || state_q == ST_FINISH);
    assign last_bit = (state_q == ST_SHIFT) && (bitcnt_q == CNT_W'(WIDTH - 1));

    // SLT runs as a subtract through the adder path.
    assign slice_op = (ctrl_q == CTRL_SLT) ? SOP_ADD : ctrl_q[1:0];

    alu_bit_slice u_slice (
        .a         (a_sh_q[0]),
        .b         (b_sh_q[0]),
        .binvert   (ctrl_q[2]),
        .cin       (carry_q),
        .less      (1'b0),
        .op        (slice_op),
        .result    (slice_res),
        .carry_out (slice_cout)
    );

    // Final result/flags, evaluated while the MSB slice is active.
    always_comb begin
        res_full = {slice_res, r_sh_q};
        msb_ovf  = carry_q ^ slice_cout;
        less_bit = slice_res ^ msb_ovf;
        res_fin  = '0;
        cout_fin = 1'b0;
        ovf_fin  = 1'b0;
        case (ctrl_q)
            CTRL_AND, CTRL_OR: begin
                res_fin = res_full;
            end
            CTRL_ADD, CTRL_SUB: begin
                res_fin  = res_full;
                cout_fin = slice_cout;
                ovf_fin  = msb_ovf;
            end
            CTRL_SLT: begin
                res_fin = {{(WIDTH - 1){1'b0}}, less_bit};
                ovf_fin = msb_ovf;
            end
`ifdef ALU24_SERIAL_XOR_EN
            CTRL_XOR: begin
                res_fin = res_full;
            end
`endif
            default: begin
                res_fin = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SHIFT;
            ST_SHIFT:  if (last_bit) state_d = ST_FINISH;
            ST_FINISH: state_d = start ? ST_SHIFT : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy = (state_q == ST_SHIFT);
        done = (state_q == ST_FINISH);
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            ctrl_q   <= '0;
            carry_q  <= 1'b0;
            bitcnt_q <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else if (accept) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            ctrl_q   <= ctrl;
            carry_q  <= ctrl[2];
            bitcnt_q <= '0;
        end else if (state_q == ST_SHIFT) begin
            a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
            r_sh_q   <= {slice_res, r_sh_q[WIDTH-2:1]};
            carry_q  <= slice_cout;
            bitcnt_q <= bitcnt_q + 1'b1;
            if (last_bit) begin
                result_q <= res_fin;
                cout_q   <= cout_fin;
                ovf_q    <= ovf_fin;
                zero_q   <= (res_fin == '0);
            end
        end
    end

    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu24_serial.sv
module tb_alu24_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] a, b;
    logic [2:0]  ctrl;
    logic [23:0] result;
    logic        carry_out, overflow, zero, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    alu24_serial dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .ctrl      (ctrl),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge after the accepting edge (cycle 1).
    task automatic launch(input logic [23:0] av, input logic [23:0] bv, input logic [2:0] c);
        @(negedge clk);
        a = av; b = bv; ctrl = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 24'($urandom);
        b = 24'($urandom);
        ctrl = 3'($urandom);
    endtask

    // Cycle index (start cycle = 0) at which done is seen; 40 means timeout.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_check(input string tag, input logic [23:0] av, input logic [23:0] bv,
                             input logic [2:0] c, input logic [23:0] er, input logic eco,
                             input logic eov, input logic ez);
        int lat;
        launch(av, bv, c);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd25);
        chk({tag, "_res"}, 32'(result), 32'(er));
        chk({tag, "_co"}, 32'(carry_out), 32'(eco));
        chk({tag, "_ov"}, 32'(overflow), 32'(eov));
        chk({tag, "_z"}, 32'(zero), 32'(ez));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, ndone, cyc;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; ctrl = '0;
        repeat (2) @(negedge clk);
        chk("rst_res", 32'(result), 32'h0);
        chk("rst_co", 32'(carry_out), 32'd0);
        chk("rst_ov", 32'(overflow), 32'd0);
        chk("rst_z", 32'(zero), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        run_check("add", 24'h000001, 24'hFFFFFF, 3'b010, 24'h000000, 1'b1, 1'b0, 1'b1);
        run_check("sub", 24'h800000, 24'h000001, 3'b110, 24'h7FFFFF, 1'b1, 1'b1, 1'b0);
        run_check("slt1", 24'hFFFFFF, 24'h000001, 3'b111, 24'h000001, 1'b0, 1'b0, 1'b0);
        run_check("slt0", 24'h000001, 24'hFFFFFF, 3'b111, 24'h000000, 1'b0, 1'b0, 1'b1);
        run_check("and", 24'hF0F0F0, 24'hFF00FF, 3'b000, 24'hF000F0, 1'b0, 1'b0, 1'b0);
        run_check("or", 24'hF0F0F0, 24'hFF00FF, 3'b001, 24'hFFF0FF, 1'b0, 1'b0, 1'b0);
        run_check("unsup", 24'h123456, 24'h654321, 3'b100, 24'h000000, 1'b0, 1'b0, 1'b1);
`ifdef ALU24_SERIAL_XOR_EN
        run_check("xor", 24'hF0F0F0, 24'hFF00FF, 3'b011, 24'h0FF00F, 1'b0, 1'b0, 1'b0);
`else
        run_check("xor", 24'hF0F0F0, 24'hFF00FF, 3'b011, 24'h000000, 1'b0, 1'b0, 1'b1);
`endif

        // Start during SHIFT is ignored; then back-to-back on the done cycle.
        launch(24'h000005, 24'h000003, 3'b010);
        cyc = 1;
        ndone = 0;
        while (!done && cyc < 40) begin
            if (cyc == 8) begin
                start = 1'b1; a = 24'h0000F0; b = 24'h00000F; ctrl = 3'b010;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("ign_lat", 32'(cyc), 32'd25);
        chk("ign_res", 32'(result), 32'h000008);
        a = 24'h100000; b = 24'h200000; ctrl = 3'b010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_pulse", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(lat);
        chk("b2b_lat", 32'(lat), 32'd25);
        chk("b2b_res", 32'(result), 32'h300000);

        // Reset mid-operation aborts without done.
        launch(24'h000001, 24'h000002, 3'b010);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res", 32'(result), 32'h0);
        chk("abort_z", 32'(zero), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_nodone", 32'(ndone), 32'd0);
        run_check("post", 24'h123456, 24'h111111, 3'b010, 24'h234567, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
